conta_votos_sessao: RTL
=======================

// Module: conta_votos_sessao
// PURPOSE
//  Sequential, parametrised vote tallier; successor of the 3-input combinational vote counter.
//  Runs a voting session: opens on start, accepts one vote per voter over a valid/ready
//  handshake, rejects duplicate and invalid votes, then scans the tallies to find the winner.
//  Sits between the voter-input front end and the result display; per-candidate counts are
//  read back through a registered readout port.
// PARAMETERS
//  N_VOTERS  3  number of voters (>=2); voter_id range 0..N_VOTERS-1
//  N_CAND    4  number of candidates (>=2); cand_id range 0..N_CAND-1
//  Derived localparams: VID_W=max(1,$clog2(N_VOTERS)), CID_W=max(1,$clog2(N_CAND)),
//                       CNT_W=$clog2(N_VOTERS+1). Counts can never overflow.
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      asynchronous active-low reset
//  start        in   1      1-cycle pulse: clear tallies and open a session (IDLE/DONE only)
//  stop         in   1      1-cycle pulse: close the session early (OPEN only)
//  vote_valid   in   1      vote present on voter_id/cand_id
//  vote_ready   out  1      1 only in OPEN; a vote is taken when vote_valid&&vote_ready
//  voter_id     in   VID_W  voter casting the vote
//  cand_id      in   CID_W  candidate voted for
//  dup_err      out  1      1-cycle pulse: accepted-handshake vote from a voter who already voted
//  inv_err      out  1      1-cycle pulse: voter_id or cand_id out of range
//  total_votes  out  CNT_W  number of counted votes this session
//  done         out  1      level, 1 in DONE; winner/tie valid while high
//  winner       out  CID_W  lowest-index candidate with the maximum count
//  tie          out  1      1 if more than one candidate holds the maximum
//  rd_cand      in   CID_W  readout select
//  rd_count     out  CNT_W  count[rd_cand], registered, 1-cycle latency, any state
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; all counts, the voted bitmap,
//   total_votes, winner, tie, done, dup_err, inv_err and rd_count = 0; vote_ready = 0.
//  FSM: IDLE -> OPEN -> SCAN -> DONE -> (start) OPEN.
//  IDLE: start -> clear counts, bitmap and total; next state OPEN.
//  OPEN: vote_ready=1. On handshake, checks run in this order:
//   - out of range -> inv_err=1 next cycle, nothing counted;
//   - voted[voter_id]=1 -> dup_err=1 next cycle, nothing counted;
//   - otherwise count[cand_id]++, voted[voter_id]<=1, total_votes++.
//   Exit to SCAN when stop=1 or the vote just counted sets the last bitmap bit.
//   A vote and stop in the same cycle: the vote is processed first, then SCAN.
//   start in OPEN is ignored.
//  SCAN: vote_ready=0. Visits idx 0..N_CAND-1, one candidate per cycle (N_CAND cycles).
//   - Register max and arg; update on strictly greater, so ties resolve to the lowest index.
//   - Track tie: set on equal to max, cleared when a new strict max is found.
//   - After the last index: winner/tie registered, state DONE. done rises exactly N_CAND+1
//     cycles after the closing edge.
//   - All-zero tallies give winner=0, tie=1.
//  DONE: done=1; winner, tie and counts held. start -> clear everything, done=0, state OPEN.
//   stop and votes ignored; vote_ready=0.
//  Handshake inputs outside OPEN are ignored with no error pulse.
//  rd_cand out of range -> rd_count=0.
//  Reset mid-session: immediate return to IDLE, all tallies lost.
// STRUCTURE
//  conta_votos_pkg:
//   - typedef enum logic [1:0] {S_IDLE,S_OPEN,S_SCAN,S_DONE} state_t
//   - function clog2_min1()
//  Sub-module conta_votos_argmax: sequential max/argmax/tie scanner with ports
//   clk, rst_n, clr, en, idx, val, max, arg, tie. Instantiated once.
//  Top module holds the FSM, the count array, the voted bitmap and the readout register.
// TESTING (defaults N_VOTERS=3, N_CAND=4)
//  1 Reset: assert rst_n=0 mid-clock -> all outputs 0 immediately, vote_ready=0.
//  2 start; votes v0->c2, v1->c2, v2->c1 -> auto-close; done after 5 cycles; winner=2,
//    tie=0, total=3; rd_cand=2 -> rd_count=2 next cycle.
//  3 start; v0->c1 twice -> second gives dup_err pulse; count[1]=1, total=1.
//  4 start; v0->c3, v1->c1, stop -> winner=1, tie=1, total=2.
//  5 start; voter_id=3 -> inv_err, total=0; stop -> winner=0, tie=1.
//  6 Reset during OPEN after 1 vote -> IDLE, count 0; start in DONE -> done=0, counts 0, OPEN.

Source files
------------

// File: rtl/conta_votos_pkg.sv
`default_nettype none
// ============================================================================
// conta_votos_pkg : shared types and helpers for the vote-session tallier
// Rev 1.0
// ============================================================================
package conta_votos_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OPEN = 2'd1,
        S_SCAN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Bit width of an index over n items, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/conta_votos_argmax.sv
`default_nettype none
// ============================================================================
// conta_votos_argmax : sequential max / argmax / tie scanner, one value per cycle
// Rev 1.0
// ============================================================================
module conta_votos_argmax #(
    parameter int CID_W = 2,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CID_W-1:0] idx,
    input  logic [CNT_W-1:0] val,
    output logic [CNT_W-1:0] max,
    output logic [CID_W-1:0] arg,
    output logic             tie
);

    // Index 0 seeds the scan, so stale results never leak into a new pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max <= '0;
            arg <= '0;
            tie <= 1'b0;
        end else if (clr) begin
            max <= '0;
            arg <= '0;
            tie <= 1'b0;
        end else if (en) begin
            if (idx == '0 || val > max) begin
                max <= val;
                arg <= idx;
                tie <= 1'b0;
            end else if (val == max) begin
                tie <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/conta_votos_sessao.sv
`default_nettype none
// ============================================================================
// conta_votos_sessao : session vote tallier with duplicate/invalid rejection
// Rev 1.0
// ============================================================================
module conta_votos_sessao
    import conta_votos_pkg::*;
#(
    parameter  int N_VOTERS = 3,
    parameter  int N_CAND   = 4,
    localparam int VID_W    = clog2_min1(N_VOTERS),
    localparam int CID_W    = clog2_min1(N_CAND),
    localparam int CNT_W    = $clog2(N_VOTERS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             vote_valid,
    output logic             vote_ready,
    input  logic [VID_W-1:0] voter_id,
    input  logic [CID_W-1:0] cand_id,
    output logic             dup_err,
    output logic             inv_err,
    output logic [CNT_W-1:0] total_votes,
    output logic             done,
    output logic [CID_W-1:0] winner,
    output logic             tie,
    input  logic [CID_W-1:0] rd_cand,
    output logic [CNT_W-1:0] rd_count
);

    localparam int SCAN_W = $clog2(N_CAND + 1);

    state_t              state, state_next;
    logic [CNT_W-1:0]    counts [N_CAND];
    logic [N_VOTERS-1:0] voted, voted_set;
    logic [SCAN_W-1:0]   scan_idx;
    logic [CNT_W-1:0]    scan_val, max_val;
    logic [CID_W-1:0]    scan_arg;
    logic                scan_tie, scan_last;
    logic                handshake, in_range, is_dup, accept, last_vote;
    logic                session_start;

    always_comb begin
        handshake     = vote_valid && vote_ready;
        in_range      = (32'(voter_id) < N_VOTERS) && (32'(cand_id) < N_CAND);
        voted_set     = '0;
        is_dup        = 1'b0;
        if (in_range) begin
            voted_set[voter_id] = 1'b1;
            is_dup              = voted[voter_id];
        end
        accept        = handshake && in_range && !is_dup;
        last_vote     = accept && ((voted | voted_set) == '1);
        session_start = start && (state == S_IDLE || state == S_DONE);
        // One extra SCAN cycle after the last index lets the scanner settle.
        scan_last     = (32'(scan_idx) == N_CAND);
        scan_val      = '0;
        if (!scan_last) scan_val = counts[scan_idx[CID_W-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start)             state_next = S_OPEN;
            S_OPEN:  if (stop || last_vote) state_next = S_SCAN;
            S_SCAN:  if (scan_last)         state_next = S_DONE;
            S_DONE:  if (start)             state_next = S_OPEN;
            default:                        state_next = S_IDLE;
        endcase
    end

    always_comb begin
        vote_ready = (state == S_OPEN);
        done       = (state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CAND; i++) counts[i] <= '0;
            voted       <= '0;
            total_votes <= '0;
            winner      <= '0;
            tie         <= 1'b0;
            dup_err     <= 1'b0;
            inv_err     <= 1'b0;
            scan_idx    <= '0;
        end else begin
            dup_err <= 1'b0;
            inv_err <= 1'b0;
            if (session_start) begin
                for (int i = 0; i < N_CAND; i++) counts[i] <= '0;
                voted       <= '0;
                total_votes <= '0;
                winner      <= '0;
                tie         <= 1'b0;
            end
            if (handshake) begin
                if (!in_range) begin
                    inv_err <= 1'b1;
                end else if (is_dup) begin
                    dup_err <= 1'b1;
                end else begin
                    counts[cand_id] <= counts[cand_id] + CNT_W'(1);
                    voted           <= voted | voted_set;
                    total_votes     <= total_votes + CNT_W'(1);
                end
            end
            if (state == S_SCAN) begin
                scan_idx <= scan_idx + SCAN_W'(1);
                if (scan_last) begin
                    winner <= scan_arg;
                    // An empty ballot box counts as a tie among everyone.
                    tie    <= scan_tie || (max_val == '0);
                end
            end else begin
                scan_idx <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_count <= '0;
        else        rd_count <= (32'(rd_cand) < N_CAND) ? counts[rd_cand] : '0;
    end

    conta_votos_argmax #(
        .CID_W (CID_W),
        .CNT_W (CNT_W)
    ) u_argmax (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (session_start),
        .en    ((state == S_SCAN) && !scan_last),
        .idx   (scan_idx[CID_W-1:0]),
        .val   (scan_val),
        .max   (max_val),
        .arg   (scan_arg),
        .tie   (scan_tie)
    );

endmodule
`default_nettype wire
